muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Control block between the main control FSM and the multiplier/divider units.
- Accepts one MULT/DIV request at a time and issues a single-cycle start pulse to the selected unit.
- Waits on that unit's done handshake with a watchdog, then commits HI/LO or raises an exception (div-by-zero, timeout, illegal op).
- Provides `busy` so the control FSM stalls MFHI/MFLO and further mult/div until HI/LO are final.

Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT-state cycles before a timeout exception; legal range 2..1023.
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  control FSM requests an operation.
- req_op  input  2  00 MULT, 01 DIV, 10/11 illegal.
- req_ready  output  1  sequencer can accept a request (IDLE only).
- abort  input  1  flush from the exception/PCClear path; cancels the current operation.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- mult_done  input  1  multiplier result valid.
- div_start  output  1  one-cycle start pulse to the divider.
- div_done  input  1  divider result valid.
- div_by_zero  input  1  divider flag; qualified by div_done.
- hilo_sel  output  1  HI/LO input mux select: 0 mult result, 1 div remainder/quotient.
- hi_write  output  1  HI load enable.
- lo_write  output  1  LO load enable.
- busy  output  1  1 whenever state != IDLE.
- op_done  output  1  one-cycle pulse when HI/LO are committed.
- exc_valid  output  1  one-cycle exception pulse.
- exc_code  output  3  exception cause; 000 when no exception.

Behaviour:
- States: IDLE, START, WAIT, COMMIT, EXC.
- Moore outputs, decoded from registered state plus the registered op/exc_code.

Reset (reset=0, asynchronous):
- State goes to IDLE, counter to 0, op to MULT, exc_code to 000.
- All strobes = 0, hilo_sel = 0, req_ready = 1, busy = 0.

IDLE:
- req_ready = 1.
- req_valid with req_op in {00,01}: latch op, go to START.
- req_valid with req_op in {10,11}: exc_code = 110, go to EXC.

START (exactly one cycle):
- mult_start = 1 if op = MULT, else div_start = 1.
- Clear counter, go to WAIT.

WAIT:
- Only the selected unit's done is sampled; the other unit's done is ignored.
- MULT with mult_done = 1: go to COMMIT.
- DIV with div_done = 1 and div_by_zero = 0: go to COMMIT.
- DIV with div_done = 1 and div_by_zero = 1: exc_code = 100, go to EXC; HI/LO are not written.
- No done and counter = TIMEOUT_CYCLES-1: exc_code = 101, go to EXC.
- Otherwise the counter increments.

COMMIT (one cycle):
- hi_write = lo_write = 1, op_done = 1, then IDLE.

EXC (one cycle):
- exc_valid = 1 with exc_code valid; HI/LO untouched; then IDLE; exc_code clears to 000 on leaving EXC.

hilo_sel:
- Equals the latched op (0 MULT, 1 DIV) from START through COMMIT, so the HI/LO input mux is stable when writes occur.

Latency:
- Accept at cycle 0, start pulse at cycle 1, WAIT from cycle 2.
- Done seen at cycle k gives COMMIT at k+1 and IDLE/req_ready at k+2.
- Minimum accept-to-accept spacing is 4 cycles.

Boundary conditions:
- abort = 1 in any non-IDLE state: IDLE next cycle, no write, no exc_valid. Abort has priority over done, div_by_zero and timeout in the same cycle. Abort in IDLE has no effect and blocks acceptance that cycle.
- req_valid while busy is ignored and not queued; the requester must hold it.
- done asserted during START is ignored; only WAIT samples done.
- Done and timeout in the same cycle: done wins.
- Reset asserted mid-operation: immediate IDLE; start pulses drop asynchronously.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding (IDLE 000, START 001, WAIT 010, COMMIT 011, EXC 100);
  - op codes OP_MULT = 2'b00, OP_DIV = 2'b01;
  - exception codes EXC_NONE 000, EXC_DIVZERO 100, EXC_TIMEOUT 101, EXC_ILLEGAL 110.
- Sub-module muldiv_watchdog: CNT_W-bit counter with clear, enable and expire (count = TIMEOUT_CYCLES-1) output.

Test Plan:
- MULT request, mult_done asserted 5 cycles after mult_start: mult_start high exactly 1 cycle, hilo_sel = 0, hi_write = lo_write = op_done = 1 at done+1, req_ready back at done+2, exc_valid never set.
- DIV 7/0 with div_done and div_by_zero together after 3 cycles: exc_valid pulse with exc_code = 100 at done+1; hi_write/lo_write stay 0; busy falls at done+2.
- DIV with done never asserted, TIMEOUT_CYCLES = 8: exc_code = 101 exactly 8 WAIT cycles after entry, then IDLE.
- abort asserted in the same cycle as mult_done: no hi_write, no op_done, no exc_valid; IDLE next cycle; a new request is accepted one cycle later.
- req_op = 11: no start pulse; exc_code = 110 one cycle after accept. req_valid held during a busy DIV: second request accepted only when req_ready returns, and no extra start pulses.
- reset driven low mid-WAIT between clock edges: busy = 0, req_ready = 1 and all strobes 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// States, op codes and exception causes seen by the control FSM.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_START  = 3'b001,
        S_WAIT   = 3'b010,
        S_COMMIT = 3'b011,
        S_EXC    = 3'b100
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;

    localparam logic [2:0] EXC_NONE    = 3'b000;
    localparam logic [2:0] EXC_DIVZERO = 3'b100;
    localparam logic [2:0] EXC_TIMEOUT = 3'b101;
    localparam logic [2:0] EXC_ILLEGAL = 3'b110;

    function automatic logic op_legal(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting on a unit's done.
// expire is high on the last allowed wait cycle.
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues MULT/DIV start pulses, waits on done with a watchdog, then
// commits HI/LO or reports an exception; busy stalls the control FSM.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    input  logic       abort,
    output logic       mult_start,
    input  logic       mult_done,
    output logic       div_start,
    input  logic       div_done,
    input  logic       div_by_zero,
    output logic       hilo_sel,
    output logic       hi_write,
    output logic       lo_write,
    output logic       busy,
    output logic       op_done,
    output logic       exc_valid,
    output logic [2:0] exc_code
);

    state_t     state;
    logic [1:0] op;
    logic [2:0] exc;
    logic       expire;
    logic       is_div;
    logic       done_sel;

    assign is_div   = (op == OP_DIV);
    assign done_sel = is_div ? div_done : mult_done;

    muldiv_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (state == S_START),
        .enable(state == S_WAIT),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op    <= OP_MULT;
            exc   <= EXC_NONE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid && !abort) begin
                        if (op_legal(req_op)) begin
                            op    <= req_op;
                            state <= S_START;
                        end else begin
                            exc   <= EXC_ILLEGAL;
                            state <= S_EXC;
                        end
                    end
                end
                S_START: begin
                    state <= abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // abort outranks done, div-by-zero and timeout
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (done_sel && is_div && div_by_zero) begin
                        exc   <= EXC_DIVZERO;
                        state <= S_EXC;
                    end else if (done_sel) begin
                        state <= S_COMMIT;
                    end else if (expire) begin
                        exc   <= EXC_TIMEOUT;
                        state <= S_EXC;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                S_EXC: begin
                    exc   <= EXC_NONE;
                    state <= S_IDLE;
                end
                default: begin
                    exc   <= EXC_NONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign mult_start = (state == S_START) && !is_div;
    assign div_start  = (state == S_START) && is_div;
    assign hilo_sel   = is_div && ((state == S_START) ||
                                   (state == S_WAIT)  ||
                                   (state == S_COMMIT));
    assign hi_write   = (state == S_COMMIT);
    assign lo_write   = (state == S_COMMIT);
    assign op_done    = (state == S_COMMIT);
    assign exc_valid  = (state == S_EXC);
    assign exc_code   = exc;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, hand sequences and
// random traffic checked against a transaction-age reference model.
module tb_muldiv_sequencer;

    localparam int T = 8;

    // output bundle: {ready,busy,mstart,dstart,sel,hw,lw,done,exc_v,code}
    localparam logic [11:0] O_IDLE = 12'h800;
    localparam logic [11:0] O_MST  = 12'h600;
    localparam logic [11:0] O_DST  = 12'h580;
    localparam logic [11:0] O_MW   = 12'h400;
    localparam logic [11:0] O_DW   = 12'h480;
    localparam logic [11:0] O_MC   = 12'h470;
    localparam logic [11:0] O_DC   = 12'h4F0;
    localparam logic [11:0] O_EDZ  = 12'h40C;
    localparam logic [11:0] O_ETO  = 12'h40D;
    localparam logic [11:0] O_EIL  = 12'h40E;

    localparam int K_COMMIT = 1;
    localparam int K_EXC    = 2;

    logic       clk = 0;
    logic       reset;
    logic       req_valid, abort, mult_done, div_done, div_by_zero;
    logic [1:0] req_op;
    logic       req_ready, mult_start, div_start, hilo_sel;
    logic       hi_write, lo_write, busy, op_done, exc_valid;
    logic [2:0] exc_code;

    int errors = 0;
    int checks = 0;
    logic [11:0] last_out;

    // reference model: age since accept (0 = idle), or a final outcome cycle
    int m_age, m_kind, m_op, m_code;
    bit m_fin;

    typedef struct {
        logic       rv;
        logic [1:0] op;
        logic       ab, md, dd, dz;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    muldiv_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
        .abort(abort),
        .mult_start(mult_start), .mult_done(mult_done),
        .div_start(div_start), .div_done(div_done),
        .div_by_zero(div_by_zero),
        .hilo_sel(hilo_sel), .hi_write(hi_write), .lo_write(lo_write),
        .busy(busy), .op_done(op_done),
        .exc_valid(exc_valid), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dut_out();
        return {req_ready, busy, mult_start, div_start, hilo_sel,
                hi_write, lo_write, op_done, exc_valid, exc_code};
    endfunction

    function automatic logic [11:0] model_out();
        logic rdy, bsy, ms, ds, sel, wr, ev;
        logic [2:0] code;
        rdy = 0; bsy = 0; ms = 0; ds = 0; sel = 0; wr = 0; ev = 0;
        code = 3'b000;
        if (m_fin && m_kind == K_COMMIT) begin
            bsy = 1; wr = 1; sel = (m_op == 1);
        end else if (m_fin) begin
            bsy = 1; ev = 1; code = 3'(m_code);
        end else if (m_age == 0) begin
            rdy = 1;
        end else begin
            bsy = 1;
            sel = (m_op == 1);
            if (m_age == 1) begin
                ms = (m_op == 0);
                ds = (m_op == 1);
            end
        end
        return {rdy, bsy, ms, ds, sel, wr, wr, wr, ev, code};
    endfunction

    task automatic model_reset();
        m_age = 0; m_fin = 0; m_kind = 0; m_op = 0; m_code = 0;
    endtask

    task automatic model_adv();
        bit d;
        if (m_fin) begin
            m_fin = 0;
            m_age = 0;
        end else if (m_age == 0) begin
            if (req_valid && !abort) begin
                if (req_op < 2) begin
                    m_op  = int'(req_op);
                    m_age = 1;
                end else begin
                    m_fin = 1; m_kind = K_EXC; m_code = 6;
                end
            end
        end else if (abort) begin
            m_age = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            d = (m_op == 1) ? div_done : mult_done;
            if (d && m_op == 1 && div_by_zero) begin
                m_fin = 1; m_kind = K_EXC; m_code = 4;
            end else if (d) begin
                m_fin = 1; m_kind = K_COMMIT;
            end else if (m_age - 2 == T - 1) begin
                m_fin = 1; m_kind = K_EXC; m_code = 5;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input string name, input bit has_exp,
                        input logic [11:0] exp);
        @(negedge clk);
        last_out = dut_out();
        chk({name, " model"}, last_out, model_out());
        if (has_exp) chk({name, " table"}, last_out, exp);
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic drive(input logic rv, input logic [1:0] op,
                         input logic ab, input logic md,
                         input logic dd, input logic dz);
        req_valid = rv; req_op = op; abort = ab;
        mult_done = md; div_done = dd; div_by_zero = dz;
    endtask

    function automatic vec_t v(input logic rv, input logic [1:0] op,
                               input logic ab, input logic md,
                               input logic dd, input logic dz,
                               input logic [11:0] e);
        vec_t r;
        r.rv = rv; r.op = op; r.ab = ab; r.md = md; r.dd = dd; r.dz = dz;
        r.exp = e;
        return r;
    endfunction

    initial begin
        int starts;
        int pd;

        // MULT, done 5 cycles after start
        vecs.push_back(v(1, 2'd0, 0, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_MST));
        for (int i = 0; i < 4; i++) vecs.push_back(v(0, 0, 0, 0, 0, 0, O_MW));
        vecs.push_back(v(0, 2'd0, 0, 1, 0, 0, O_MW));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_MC));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_IDLE));
        // DIV by zero, done after 3 cycles
        vecs.push_back(v(1, 2'd1, 0, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_DST));
        vecs.push_back(v(0, 2'd0, 0, 1, 0, 0, O_DW));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_DW));
        vecs.push_back(v(0, 2'd0, 0, 0, 1, 1, O_DW));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_EDZ));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_IDLE));
        // abort with mult_done, then a new request
        vecs.push_back(v(1, 2'd0, 0, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_MST));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_MW));
        vecs.push_back(v(0, 2'd0, 1, 1, 0, 0, O_MW));
        vecs.push_back(v(1, 2'd0, 0, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_MST));
        vecs.push_back(v(0, 2'd0, 1, 0, 0, 0, O_MW));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_IDLE));
        // illegal op, abort in idle
        vecs.push_back(v(1, 2'd3, 0, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_EIL));
        vecs.push_back(v(1, 2'd0, 1, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_IDLE));
        // done during START ignored
        vecs.push_back(v(1, 2'd0, 0, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 1, 0, 0, O_MST));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_MW));
        vecs.push_back(v(0, 2'd0, 0, 1, 0, 0, O_MW));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_MC));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_IDLE));
        // DIV done on the last wait cycle beats timeout
        vecs.push_back(v(1, 2'd1, 0, 0, 0, 0, O_IDLE));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_DST));
        for (int i = 0; i < T - 1; i++)
            vecs.push_back(v(0, 0, 0, 0, 0, 0, O_DW));
        vecs.push_back(v(0, 2'd0, 0, 0, 1, 0, O_DW));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_DC));
        vecs.push_back(v(0, 2'd0, 0, 0, 0, 0, O_IDLE));

        reset = 0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", dut_out(), O_IDLE);
        reset = 1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rv, vecs[i].op, vecs[i].ab,
                  vecs[i].md, vecs[i].dd, vecs[i].dz);
            step($sformatf("vec%0d", i), 1, vecs[i].exp);
        end

        // DIV timeout after exactly T wait cycles
        drive(1, 2'd1, 0, 0, 0, 0);
        step("to_accept", 1, O_IDLE);
        drive(0, 0, 0, 0, 0, 0);
        step("to_start", 1, O_DST);
        for (int i = 0; i < T; i++) step("to_wait", 1, O_DW);
        step("to_exc", 1, O_ETO);
        step("to_idle", 1, O_IDLE);

        // request held across a busy DIV
        starts = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 2'd1, 0, 0, i == 3, 0);
            step("held", 0, '0);
            starts += int'(last_out[9]) + int'(last_out[8]);
        end
        checks++;
        if (starts != 2) begin
            errors++;
            $display("FAIL held_starts: got %0d expected 2", starts);
        end
        drive(0, 0, 0, 0, 0, 0);
        step("held_w", 0, '0);
        drive(0, 0, 0, 0, 1, 0);
        step("held_d", 0, '0);
        drive(0, 0, 0, 0, 0, 0);
        step("held_c", 1, O_DC);
        step("held_i", 1, O_IDLE);

        // async reset mid-WAIT and mid-START
        for (int k = 0; k < 2; k++) begin
            drive(1, 2'd0, 0, 0, 0, 0);
            step("ar_acc", 0, '0);
            drive(0, 0, 0, 0, 0, 0);
            if (k == 0) begin
                step("ar_st", 0, '0);
                step("ar_w", 0, '0);
            end
            #2;
            reset = 0;
            #1;
            chk(k == 0 ? "async_reset_wait" : "async_reset_start",
                dut_out(), O_IDLE);
            model_reset();
            @(negedge clk);
            reset = 1;
            @(posedge clk);
            #1;
        end

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pd = ((i / 200) % 3 == 0) ? 2 : 25;
            drive($urandom_range(0, 99) < 50,
                  ($urandom_range(0, 9) == 0) ? 2'(2 + $urandom_range(0, 1))
                                              : 2'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < pd,
                  $urandom_range(0, 99) < pd,
                  $urandom_range(0, 99) < 30);
            step("rand", 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
